// File: rtl/mux_sev_seg_scanner_if.sv
// Datapath-side bundle for mux_sev_seg_scanner.
// Master writes value/brightness and sees frame status.
`timescale 1ns/1ps
interface mux_sev_seg_scanner_if #(
  parameter int DIGITS = 4,
  parameter int DUTY_W = 4
);
  logic                  LOAD;
  logic [4*DIGITS-1:0]   HEX;
  logic [DIGITS-1:0]     DP;
  logic [DUTY_W-1:0]     BRIGHT;
  logic                  FRAME;
  logic                  PENDING;

  modport master (
    output LOAD, HEX, DP, BRIGHT,
    input  FRAME, PENDING
  );

  modport slave (
    input  LOAD, HEX, DP, BRIGHT,
    output FRAME, PENDING
  );
endinterface

// File: rtl/mux_sev_seg_scanner.sv
// Multiplexed 7-seg scanner: double-buffered, per-digit DP, PWM dimming.
// Define MSS_LZ_BLANK_EN for leading-zero blanking.
`timescale 1ns/1ps
module mux_sev_seg_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 4096,
  parameter int DUTY_W   = 4,
  parameter int INV      = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mux_sev_seg_scanner_if.slave bus,
  output logic [DIGITS-1:0]    CAT,
  output logic [6:0]           SEG,
  output logic                 DP_OUT
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [6:0] SEG_OFF = (INV != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (INV != 0);

  logic [PW-1:0]       pc;
  logic [IW-1:0]       idx;
  logic [DUTY_W-1:0]   pw;
  logic [4*DIGITS-1:0] pend_hex, act_hex;
  logic [DIGITS-1:0]   pend_dp, act_dp;
  logic                pending;
  logic                slot_end, swap;

  logic [DIGITS-1:0]   cat_d;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic                frame_q;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_end = (pc == PW'(PRESCALE-1));
  assign swap     = slot_end && (idx == IW'(DIGITS-1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc <= '0;
      idx <= '0;
      pw <= '0;
    end else begin
      pw <= pw + 1'b1;
      if (slot_end) begin
        pc <= '0;
        idx <= swap ? '0 : idx + 1'b1;
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

  // A load landing on the swap cycle bypasses straight to the active buffer
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_hex <= '0;
      pend_dp  <= '0;
      act_hex  <= '0;
      act_dp   <= '0;
      pending  <= 1'b0;
    end else if (swap) begin
      if (bus.LOAD) begin
        pend_hex <= bus.HEX;
        pend_dp  <= bus.DP;
        act_hex  <= bus.HEX;
        act_dp   <= bus.DP;
      end else if (pending) begin
        act_hex <= pend_hex;
        act_dp  <= pend_dp;
      end
      pending <= 1'b0;
    end else if (bus.LOAD) begin
      pend_hex <= bus.HEX;
      pend_dp  <= bus.DP;
      pending  <= 1'b1;
    end
  end

  always_comb begin
    logic       on;
    logic [3:0] nib;
    logic [6:0] seg_a;
    logic       dp_a;
`ifdef MSS_LZ_BLANK_EN
    logic       lz;
`endif
    on    = (pw <= bus.BRIGHT);
    nib   = act_hex[4*(DIGITS-1-int'(idx)) +: 4];
    dp_a  = act_dp[DIGITS-1-int'(idx)];
    seg_a = decode(nib);
`ifdef MSS_LZ_BLANK_EN
    lz = (idx != IW'(DIGITS-1));
    for (int i = 0; i < DIGITS; i++) begin
      if (i <= int'(idx) && act_hex[4*(DIGITS-1-i) +: 4] != 4'h0)
        lz = 1'b0;
    end
    if (lz)
      seg_a = 7'h00;
`endif
    cat_d = '0;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (on) begin
      cat_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
      seg_d = (INV != 0) ? ~seg_a : seg_a;
      dp_d  = (INV != 0) ? ~dp_a : dp_a;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      CAT     <= '0;
      SEG     <= SEG_OFF;
      DP_OUT  <= DP_OFF;
      frame_q <= 1'b0;
    end else begin
      CAT     <= cat_d;
      SEG     <= seg_d;
      DP_OUT  <= dp_d;
      frame_q <= swap;
    end
  end

  assign bus.FRAME   = frame_q;
  assign bus.PENDING = pending;

endmodule

// File: tb/tb_mux_sev_seg_scanner.sv
// Directed bench for mux_sev_seg_scanner at DIGITS=4, PRESCALE=4,
// DUTY_W=2, INV=1.
`timescale 1ns/1ps
module tb_mux_sev_seg_scanner;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] CAT;
  logic [6:0] SEG;
  logic       DP_OUT;
  int         total = 0;
  int         bad = 0;

  mux_sev_seg_scanner_if #(.DIGITS(4), .DUTY_W(2)) bus ();

  mux_sev_seg_scanner #(
    .DIGITS(4), .PRESCALE(4), .DUTY_W(2), .INV(1)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus),
    .CAT(CAT),
    .SEG(SEG),
    .DP_OUT(DP_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the DUT so that the next edge is cycle 0 after release
  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    bus.LOAD = 1'b1;
    bus.HEX = 16'h9999;
    RESET = 1'b1;
    tick();
    tick();
    total += 5;
    if (CAT !== 4'b0000) begin bad++; $display("FAIL rst_cat got=%b exp=0000", CAT); end
    if (SEG !== 7'h7F) begin bad++; $display("FAIL rst_seg got=%h exp=7f", SEG); end
    if (DP_OUT !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b exp=1", DP_OUT); end
    if (bus.PENDING !== 1'b0) begin bad++; $display("FAIL rst_pend got=%b exp=0", bus.PENDING); end
    if (bus.FRAME !== 1'b0) begin bad++; $display("FAIL rst_frame got=%b exp=0", bus.FRAME); end
    bus.LOAD = 1'b0;
    RESET = 1'b0;
    tick();
    total += 2;
    if (CAT !== 4'b0001) begin bad++; $display("FAIL rel_cat got=%b exp=0001", CAT); end
    if (SEG !== 7'h40) begin bad++; $display("FAIL rel_seg got=%h exp=40", SEG); end
  endtask

  task automatic test_scan_order();
    logic [6:0] tbl [4];
    logic [6:0] es;
    logic [3:0] ec;
    logic       ep, ef;
    tbl = '{7'h79, 7'h08, 7'h30, 7'h0E};
    do_reset();
    bus.HEX = 16'h1A3F;
    bus.DP = 4'b0000;
    for (int k = 0; k < 36; k++) begin
      bus.LOAD = (k == 2);
      tick();
      ec = 4'b0001 << ((k / 4) % 4);
      es = (k >= 16 && k < 32) ? tbl[(k - 16) / 4] : (k < 16 ? 7'h40 : tbl[(k - 32) / 4]);
      ep = (k >= 2 && k <= 14);
      ef = (k == 15 || k == 31);
      total += 4;
      if (CAT !== ec) begin bad++; $display("FAIL scan_cat k=%0d got=%b exp=%b", k, CAT, ec); end
      if (SEG !== es) begin bad++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, SEG, es); end
      if (bus.PENDING !== ep) begin bad++; $display("FAIL scan_pend k=%0d got=%b exp=%b", k, bus.PENDING, ep); end
      if (bus.FRAME !== ef) begin bad++; $display("FAIL scan_frame k=%0d got=%b exp=%b", k, bus.FRAME, ef); end
    end
    bus.LOAD = 1'b0;
  endtask

  task automatic test_double_buffer();
    logic [6:0] es;
    int         frames;
    frames = 0;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      bus.LOAD = (k == 3 || k == 8);
      bus.HEX = (k == 3) ? 16'h1111 : 16'h2222;
      tick();
      if (k < 16 && bus.FRAME === 1'b1)
        frames++;
      es = (k < 16) ? 7'h40 : 7'h24;
      total++;
      if (SEG !== es) begin bad++; $display("FAIL dbuf_seg k=%0d got=%h exp=%h", k, SEG, es); end
    end
    bus.LOAD = 1'b0;
    total++;
    if (frames !== 1) begin bad++; $display("FAIL dbuf_frames got=%0d exp=1", frames); end
  endtask

  task automatic test_swap_load();
    logic [6:0] es;
    do_reset();
    bus.HEX = 16'h8888;
    for (int k = 0; k < 24; k++) begin
      bus.LOAD = (k == 15);
      tick();
      es = (k < 16) ? 7'h40 : 7'h00;
      total += 2;
      if (SEG !== es) begin bad++; $display("FAIL swapld_seg k=%0d got=%h exp=%h", k, SEG, es); end
      if (bus.PENDING !== 1'b0) begin bad++; $display("FAIL swapld_pend k=%0d got=%b exp=0", k, bus.PENDING); end
    end
    bus.LOAD = 1'b0;
  endtask

  task automatic test_brightness();
    logic [3:0] ec;
    logic [6:0] es;
    logic       ed, on;
    bus.BRIGHT = 2'd0;
    do_reset();
    bus.HEX = 16'h0000;
    bus.DP = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      bus.LOAD = (k == 0);
      tick();
      on = ((k % 4) == 0);
      ec = on ? (4'b0001 << ((k / 4) % 4)) : 4'b0000;
      es = on ? 7'h40 : 7'h7F;
      ed = !(on && k >= 16 && ((k / 4) % 4) == 3);
      total += 3;
      if (CAT !== ec) begin bad++; $display("FAIL bri_cat k=%0d got=%b exp=%b", k, CAT, ec); end
      if (SEG !== es) begin bad++; $display("FAIL bri_seg k=%0d got=%h exp=%h", k, SEG, es); end
      if (DP_OUT !== ed) begin bad++; $display("FAIL bri_dp k=%0d got=%b exp=%b", k, DP_OUT, ed); end
    end
    bus.LOAD = 1'b0;
    bus.DP = 4'b0000;
    bus.BRIGHT = 2'd3;
  endtask

  task automatic test_blanking();
    logic [6:0] tbl [4];
    logic [6:0] es;
`ifdef MSS_LZ_BLANK_EN
    tbl = '{7'h7F, 7'h7F, 7'h19, 7'h40};
`else
    tbl = '{7'h40, 7'h40, 7'h19, 7'h40};
`endif
    do_reset();
    bus.HEX = 16'h0040;
    for (int k = 0; k < 32; k++) begin
      bus.LOAD = (k == 0);
      tick();
      es = (k < 16) ? 7'h40 : tbl[(k - 16) / 4];
      total++;
      if (SEG !== es) begin bad++; $display("FAIL blank_seg k=%0d got=%h exp=%h", k, SEG, es); end
    end
    bus.LOAD = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.HEX = 16'h5555;
    for (int k = 0; k < 6; k++) begin
      bus.LOAD = (k == 3);
      tick();
    end
    RESET = 1'b1;
    bus.LOAD = 1'b1;
    bus.HEX = 16'h7777;
    tick();
    total += 2;
    if (bus.PENDING !== 1'b0) begin bad++; $display("FAIL midrst_pend got=%b exp=0", bus.PENDING); end
    if (CAT !== 4'b0000) begin bad++; $display("FAIL midrst_cat got=%b exp=0000", CAT); end
    RESET = 1'b0;
    bus.LOAD = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      total += 2;
      if (SEG !== 7'h40) begin bad++; $display("FAIL midrst_seg k=%0d got=%h exp=40", k, SEG); end
      if (bus.PENDING !== 1'b0) begin bad++; $display("FAIL midrst_p k=%0d got=%b exp=0", k, bus.PENDING); end
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus.LOAD = 1'b0;
    bus.HEX = '0;
    bus.DP = '0;
    bus.BRIGHT = 2'd3;
    test_reset();
    test_scan_order();
    test_double_buffer();
    test_swap_load();
    test_brightness();
    test_blanking();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_sev_seg_scanner.md
# mux_sev_seg_scanner

- Parametrised, single-clock multiplexed seven-segment display driver.
- Scans `DIGITS` common-cathode positions with an internal refresh prescaler and double-buffers the displayed value, so loads never tear mid-frame.
- Adds per-digit decimal points and PWM brightness.
- Sits between the numeric datapath (writer of `HEX`/`DP`) and the board display pins; supersedes the fixed 4-digit externally-clocked controller.

## Interface

Parameters:
- `DIGITS`, 4, number of display positions (≥2).
- `PRESCALE`, 4096, clock cycles per digit slot (≥2).
- `DUTY_W`, 4, brightness control width.
- `INV`, 1, 1 = active-low segment/DP outputs; 0 = active-high.

Ports:
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `LOAD`  in  1  single-cycle write strobe for `HEX`/`DP`.
- `HEX`  in  4*DIGITS  value to display; top nibble is leftmost digit.
- `DP`  in  DIGITS  decimal-point enables; `DP[DIGITS-1]` is leftmost digit.
- `BRIGHT`  in  DUTY_W  brightness; all-ones = full on.
- `CAT`  out  DIGITS  one-hot digit enable, active-high; `CAT[0]` = leftmost digit.
- `SEG`  out  7  segments, `SEG[0]`=a … `SEG[6]`=g, polarity per `INV`.
- `DP_OUT`  out  1  decimal point of the lit digit, polarity per `INV`.
- `FRAME`  out  1  one-cycle pulse at every frame wrap.
- `PENDING`  out  1  loaded data waiting for the next frame boundary.

## Operation

- **Registers:** prescale counter `pc` (0..PRESCALE-1), digit index `idx` (0..DIGITS-1), free-running PWM counter `pw` (DUTY_W bits), pending buffer, active buffer.
- **Counters:** `pc` increments every cycle. At `pc==PRESCALE-1`, `pc`←0 and `idx` advances. `idx==DIGITS-1` wraps to 0; that cycle is the *swap cycle*.
- **Load:** `LOAD` captures `HEX`/`DP` into the pending buffer and sets `PENDING`. Multiple loads within one frame: the last one wins.
- **Swap:**
  - On the swap cycle with `PENDING`=1: active←pending, `PENDING`←0, `FRAME` pulses.
  - Swap cycle with `LOAD` also asserted: `HEX`/`DP` go directly to active and pending, and `PENDING` stays 0 (bypass).
- **Digit select:**
  - Digit `idx` shows nibble `active[4*(DIGITS-1-idx) +: 4]` and `DP[DIGITS-1-idx]`.
  - `CAT` = `1<<idx` when `pw ≤ BRIGHT`, else all-zero.
  - While `CAT` is zero, `SEG`/`DP_OUT` drive the off level.
- **Decode (active-high, before `INV`):**
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
- **Polarity:** `INV`=1 inverts `SEG` and `DP_OUT`. `CAT` is never inverted.

## Timing

- `CAT`, `SEG`, `DP_OUT` and `FRAME` are registered: each reflects `idx`/`pw` state one cycle after that state changes.
- **Frame period:** `DIGITS*PRESCALE` cycles. Each digit slot is exactly `PRESCALE` cycles.
- **Load latency:** new data is first visible on the first digit-0 slot after the next swap cycle, at most `DIGITS*PRESCALE+1` cycles after `LOAD`.
- **PWM:** period 2^DUTY_W cycles; on-time `BRIGHT+1` cycles. `BRIGHT`=0 gives 1/2^DUTY_W duty.
- **Reset, effective the cycle it is sampled and overriding `LOAD`:**
  - `pc`, `idx`, `pw`, both buffers ← 0.
  - `CAT`=0, `SEG`=off level (7F if `INV`, else 00), `DP_OUT`=off, `FRAME`=0, `PENDING`=0.
- **First cycle after `RESET` deasserts:** `CAT`=1, digit 0 shows "0".
- **Reset mid-frame:** a pending load is discarded.

## Configuration

- **`MSS_LZ_BLANK_EN` defined:** leading-zero blanking.
  - A digit whose nibble is 0 and whose more-significant nibbles are all 0 drives `SEG` off.
  - The rightmost digit is never blanked.
  - `DP_OUT` and `CAT` are unaffected.
- **Not defined:** every digit decodes its nibble normally.

## Test plan

Bench parameters: `DIGITS`=4, `PRESCALE`=4, `DUTY_W`=2, `INV`=1, `BRIGHT`=3 unless stated.

- **Reset:** `RESET` high for 2 cycles → `CAT`=0, `SEG`=7F, `DP_OUT`=1, `PENDING`=0. First cycle after release → `CAT`=0001, `SEG`=40.
- **Scan order:** `LOAD` `HEX`=1A3F at cycle 2 → `PENDING`=1 until the swap at cycle 15. Next frame, each `CAT` slot lasts 4 cycles:
  - `CAT`=0001 → `SEG`=79
  - `CAT`=0010 → `SEG`=08
  - `CAT`=0100 → `SEG`=30
  - `CAT`=1000 → `SEG`=0E
- **Double buffer:** `LOAD` 1111 then `LOAD` 2222 in the same frame → only 2222 ever displayed; `FRAME` pulses once.
- **Swap-cycle load:** `LOAD` 8888 exactly on the swap cycle → digit 0 next slot shows `SEG`=00; `PENDING` stays 0.
- **Brightness:** `BRIGHT`=0 → `CAT` non-zero 1 cycle in 4, `SEG`=7F otherwise. `DP`=0001 → `DP_OUT`=0 only while `CAT`=1000 is lit.
- **Blanking:** with `MSS_LZ_BLANK_EN`, `HEX`=0040 → digits 0–1 `SEG`=7F, digit 2 `SEG`=19, digit 3 `SEG`=40. Without the macro, digits 0–1 show `SEG`=40.
